alu_seq_core: RTL and testbench
===============================

# alu_seq_core

Parametrised, registered successor to the processor's 4-bit combinational ALU result mux. The block accepts an opcode and two `WIDTH`-bit operands through a valid/ready handshake, computes one of eight operations, and returns a registered result with Z/C/N flags. Shifts by a variable amount run serially, one bit per cycle. The block sits between the operand/register-file stage and write-back.

## Interface
Parameters:
- `WIDTH`, 4: operand/result width; must be ≥ 2.
- `AMT_W`, `$clog2(WIDTH)+1`: width of the shift-amount field taken from `b[AMT_W-1:0]`.

Ports:
- `clk` input, 1 bit: single clock; all state changes on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `in_valid` input, 1 bit: request strobe.
- `in_ready` output, 1 bit: block can accept a request.
- `opcode` input, 3 bits: operation select.
- `a` input, `WIDTH` bits: operand A.
- `b` input, `WIDTH` bits: operand B, or the shift amount for shift operations.
- `out_valid` output, 1 bit: one-cycle pulse; `result` and `flags` are fresh.
- `result` output, `WIDTH` bits: registered result; held until the next completion.
- `flags` output, 3 bits: registered `{N, C, Z}`; held until the next completion.

## Operation
- A request is accepted on any rising edge where `in_valid && in_ready`. `opcode`, `a` and `b` are captured on that edge.
- Opcodes:
  - 0 ADD: `a + b`; C is the carry-out.
  - 1 COMP: two's complement `-a`; C = 1 iff `a == 0`.
  - 2 SHR: logical right shift of `a` by `amt`.
  - 3 SHL: logical left shift of `a` by `amt`.
  - 4 CMPC: result = `{'0, (a < b) unsigned}`; C = that bit.
  - 5 CMPN: result = `{'0, (a < b) signed}`; C = 0.
  - 6 ONE: result = 1.
  - 7 LOAD: result = `b`.
- `amt` = `b[AMT_W-1:0]`, unsigned.
- Flags for every operation:
  - Z = (result == 0).
  - N = result[WIDTH-1].
  - C = 0 unless the opcode defines it above.
- All arithmetic is modulo 2^WIDTH. There is no overflow flag.
- Shifts:
  - C is the last bit shifted out.
  - `amt == 0`: result = `a`, C = 0.
  - `amt ≥ WIDTH`: result = 0, completes in a single cycle; C = `a[0]` (SHR) or `a[WIDTH-1]` (SHL).
- State machine `IDLE` / `SHIFT`:
  - `IDLE`: `in_ready = 1`.
  - An accepted SHR/SHL with `1 ≤ amt < WIDTH` loads the working register with `a` and the counter with `amt`, then goes to `SHIFT`.
  - Every other accepted request writes `result`/`flags` directly and stays in `IDLE`.
  - `SHIFT`: `in_ready = 0`. Each edge shifts the working register by one bit, latches the shifted-out bit into C, and decrements the counter.
  - When the counter goes 1→0, the edge writes `result`/`flags`, pulses `out_valid`, and returns to `IDLE`.
- `in_valid` asserted while `in_ready = 0` is ignored. Requesters hold their inputs until they see `in_ready`.
- `out_valid` has no back-pressure. The consumer must take the result in the pulse cycle.

## Timing
- Reset: `state = IDLE`, `in_ready = 1`, `out_valid = 0`, `result = 0`, `flags = 3'b001` (Z set), counter = 0.
- Single-cycle operations (all non-shifts, shifts with `amt == 0`, shifts with `amt ≥ WIDTH`):
  - Request accepted at edge E0; `out_valid` is high in the cycle following E0.
  - A new request may be accepted at E0+1, giving back-to-back throughput of 1 per cycle.
- Serial shift with `1 ≤ amt = k < WIDTH`:
  - Accepted at E0; `out_valid` is high in the cycle following edge E0+k.
  - `in_ready` is low from after E0 until after E0+k.
  - A new request may be accepted at E0+k+1.
- `rst` asserted mid-shift aborts the operation at that edge. No `out_valid` is produced, and the outputs take their reset values.
- `rst` has priority over acceptance on the same edge.

## Structure
- Package `alu_pkg`:
  - Opcode localparams `OP_ADD` … `OP_LOAD` (3-bit).
  - State enum `{IDLE, SHIFT}`.
  - Flag bit indices `FLAG_Z = 0`, `FLAG_C = 1`, `FLAG_N = 2`.
- Sub-module `alu_serial_shifter`:
  - Holds the working register, counter and direction.
  - Ports: `start`, `dir`, `data`, `amt`; outputs `busy`, `done`, `q`, `last_out`.
- The top level holds the FSM glue, the single-cycle datapath and the output registers.

## Test plan
All scenarios use `WIDTH = 8`.
- Reset release: check `result = 0`, `flags = 3'b001`, `in_ready = 1`. Then ADD `a = 8'hF0`, `b = 8'h20` → `out_valid` one cycle later, `result = 8'h10`, `flags = {N0, C1, Z0}`.
- Back-to-back: COMP `a = 0` → `result = 0`, C = 1, Z = 1. Next cycle CMPN `a = 8'h80`, `b = 8'h01` → `result = 1`, `flags = 3'b000`. `out_valid` is high on consecutive cycles.
- SHL `a = 8'h81`, `amt = 3`: `in_ready` is low for 3 cycles, `out_valid` comes 3 cycles after acceptance, `result = 8'h08`, C = 0. A request held during the shift is accepted exactly when `in_ready` returns.
- Shift edges:
  - SHR `a = 8'hFF`, `amt = 0` → `8'hFF`, C = 0, one cycle.
  - SHR `a = 8'h01`, `amt = 8` → `8'h00`, C = 1, Z = 1, one cycle.
  - SHR `a = 8'h80`, `amt = 7` → `8'h01` after 7 cycles.
- Reset mid-shift: SHL `amt = 5`, assert `rst` at the 2nd shift edge → no `out_valid` ever, reset values, `in_ready = 1` next cycle.
- CMPC `a = 8'h01`, `b = 8'hFF` → `result = 1`, C = 1. CMPN with the same operands → `result = 0`, Z = 1. ONE → `8'h01`. LOAD `b = 8'hA5` → `8'hA5`, N = 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and flag bit positions for the
// sequential ALU core.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_COMP = 3'd1;
  localparam logic [2:0] OP_SHR  = 3'd2;
  localparam logic [2:0] OP_SHL  = 3'd3;
  localparam logic [2:0] OP_CMPC = 3'd4;
  localparam logic [2:0] OP_CMPN = 3'd5;
  localparam logic [2:0] OP_ONE  = 3'd6;
  localparam logic [2:0] OP_LOAD = 3'd7;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;

endpackage

// File: rtl/alu_serial_shifter.sv
// One-bit-per-cycle logical shifter. q/last_out present the value and the
// outgoing bit of the step taken on the coming edge; done marks the final step.
module alu_serial_shifter #(
  parameter int WIDTH = 4,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] data,
  input  logic [AMT_W-1:0] amt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic             last_out
);

  logic [AMT_W-1:0] cnt_q;
  logic [WIDTH-1:0] work_q;
  logic             dir_q;

  // dir = 1 shifts left, dir = 0 shifts right
  assign busy     = (cnt_q != '0);
  assign done     = (cnt_q == AMT_W'(1));
  assign q        = dir_q ? {work_q[WIDTH-2:0], 1'b0} : {1'b0, work_q[WIDTH-1:1]};
  assign last_out = dir_q ? work_q[WIDTH-1] : work_q[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= amt;
    end else if (busy) begin
      cnt_q <= cnt_q - AMT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      work_q <= data;
      dir_q  <= dir;
    end else if (busy) begin
      work_q <= q;
    end
  end

endmodule

// File: rtl/alu_seq_core.sv
// Registered ALU with valid/ready request side and a one-cycle out_valid pulse.
// Variable shifts in range 1..WIDTH-1 run serially; everything else completes next cycle.
module alu_seq_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       flags
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [2:0]       flags_q, flags_d;
  logic             vld_q, vld_d;

  logic [AMT_W-1:0]        amt;
  logic                    amt_big, is_shift, serial, sh_start;
  logic [WIDTH:0]          sum;
  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH-1:0]        alu_res, sh_q;
  logic                    alu_c, sh_busy, sh_done, sh_last;

  function automatic logic [2:0] make_flags(input logic [WIDTH-1:0] r, input logic c);
    logic [2:0] f;
    f         = '0;
    f[FLAG_Z] = (r == '0);
    f[FLAG_C] = c;
    f[FLAG_N] = r[WIDTH-1];
    return f;
  endfunction

  assign amt      = b[AMT_W-1:0];
  assign amt_big  = (amt >= AMT_W'(WIDTH));
  assign is_shift = (opcode == OP_SHR) || (opcode == OP_SHL);
  assign serial   = is_shift && (amt != '0) && !amt_big;
  assign sum      = {1'b0, a} + {1'b0, b};
  assign a_s      = a;
  assign b_s      = b;

  // Single-cycle datapath; shift paths here only cover amt == 0 and amt >= WIDTH
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (opcode)
      OP_ADD:  {alu_c, alu_res} = sum;
      OP_COMP: begin
        alu_res = -a;
        alu_c   = (a == '0);
      end
      OP_SHR:  begin
        if (amt == '0) alu_res = a;
        else           alu_c   = a[0];
      end
      OP_SHL:  begin
        if (amt == '0) alu_res = a;
        else           alu_c   = a[WIDTH-1];
      end
      OP_CMPC: begin
        alu_c   = (a < b);
        alu_res = WIDTH'(alu_c);
      end
      OP_CMPN: alu_res = WIDTH'(a_s < b_s);
      OP_ONE:  alu_res = WIDTH'(1);
      default: alu_res = b;
    endcase
  end

  alu_serial_shifter #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .start    (sh_start),
    .dir      (opcode == OP_SHL),
    .data     (a),
    .amt      (amt),
    .busy     (sh_busy),
    .done     (sh_done),
    .q        (sh_q),
    .last_out (sh_last)
  );

  assign in_ready = (state_q == IDLE);

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    vld_d    = 1'b0;
    sh_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (serial) begin
            sh_start = 1'b1;
            state_d  = SHIFT;
          end else begin
            result_d = alu_res;
            flags_d  = make_flags(alu_res, alu_c);
            vld_d    = 1'b1;
          end
        end
      end
      default: begin
        if (sh_done) begin
          result_d = sh_q;
          flags_d  = make_flags(sh_q, sh_last);
          vld_d    = 1'b1;
          state_d  = IDLE;
        end else if (!sh_busy) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      flags_q  <= 3'b001;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      vld_q    <= vld_d;
    end
  end

  assign out_valid = vld_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed bench for alu_seq_core (WIDTH = 8) with a queue scoreboard of
// expected result/flags/completion cycle.
module tb_alu_seq_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] opcode;
  logic [7:0] a, b;
  logic       out_valid;
  logic [7:0] result;
  logic [2:0] flags;

  typedef struct {
    logic [7:0] res;
    logic [2:0] flg;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;

  alu_seq_core #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Holds the request from a falling edge until in_ready is seen, then lets one edge accept it.
  task automatic send(input logic [2:0] op, input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] er, input logic [2:0] ef, input int lat,
                      input bit push, output int acc, output int waits);
    @(negedge clk);
    in_valid = 1'b1;
    opcode   = op;
    a        = av;
    b        = bv;
    waits    = 0;
    while (!in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    chk("ready_wait", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    acc      = cyc;
    if (push) sb.push_back('{er, ef, cyc + lat});
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_out_valid", out_valid, 0);
      end else begin
        cur = sb.pop_front();
        chk("result", result, cur.res);
        chk("flags", flags, cur.flg);
        chk("done_cycle", cyc, cur.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0, acc1, acc2, w0, w1;
    rst      = 1'b1;
    in_valid = 1'b0;
    opcode   = 3'd0;
    a        = 8'h00;
    b        = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_result", result, 8'h00);
    chk("rst_flags", flags, 3'b001);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);

    send(3'd0, 8'hF0, 8'h20, 8'h10, 3'b010, 0, 1, acc0, w0);

    // Back-to-back single-cycle operations
    send(3'd1, 8'h00, 8'h00, 8'h00, 3'b011, 0, 1, acc0, w0);
    send(3'd5, 8'h80, 8'h01, 8'h01, 3'b000, 0, 1, acc1, w1);
    chk("b2b_accept", acc1, acc0 + 1);

    // Serial shift with a request held while busy
    send(3'd3, 8'h81, 8'h03, 8'h08, 3'b000, 3, 1, acc0, w0);
    send(3'd0, 8'h01, 8'h02, 8'h03, 3'b000, 0, 1, acc1, w1);
    chk("busy_cycles", w1, 3);
    chk("held_accept", acc1, acc0 + 4);

    send(3'd2, 8'hFF, 8'h00, 8'hFF, 3'b100, 0, 1, acc0, w0);
    send(3'd2, 8'h01, 8'h08, 8'h00, 3'b011, 0, 1, acc0, w0);
    send(3'd2, 8'h80, 8'h07, 8'h01, 3'b000, 7, 1, acc0, w0);
    send(3'd2, 8'h81, 8'h01, 8'h40, 3'b010, 1, 1, acc0, w0);
    send(3'd3, 8'h81, 8'h09, 8'h00, 3'b011, 0, 1, acc0, w0);

    send(3'd4, 8'h01, 8'hFF, 8'h01, 3'b010, 0, 1, acc0, w0);
    send(3'd5, 8'h01, 8'hFF, 8'h00, 3'b001, 0, 1, acc0, w0);
    send(3'd6, 8'h55, 8'h55, 8'h01, 3'b000, 0, 1, acc0, w0);
    send(3'd7, 8'h00, 8'hA5, 8'hA5, 3'b100, 0, 1, acc0, w0);
    send(3'd1, 8'h01, 8'h00, 8'hFF, 3'b100, 0, 1, acc0, w0);
    send(3'd0, 8'hFF, 8'h01, 8'h00, 3'b011, 0, 1, acc0, w0);
    send(3'd6, 8'h00, 8'h00, 8'h01, 3'b000, 0, 1, acc0, w0);

    // Reset lands on the second shift edge of a 5-step SHL
    send(3'd3, 8'h81, 8'h05, 8'h00, 3'b000, 5, 0, acc2, w0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_result", result, 8'h00);
    chk("abort_flags", flags, 3'b001);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    repeat (8) @(negedge clk);

    send(3'd0, 8'h12, 8'h34, 8'h46, 3'b000, 0, 1, acc0, w0);
    repeat (10) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
